// File: rtl/generic_rom_mc_w.sv
// generic_rom_mc_w: NUM_CH valid/ready requesters sharing one single-port ROM
// through a round-robin arbiter, with a one-entry response slot per channel.

// Single-port ROM with a registered read. Data for the address presented with
// i_en high appears on o_data in the following cycle and is held otherwise.
module generic_rom #(
   parameter int    MEM_ADDR_BITS = 10,
   parameter int    MEM_DATA_BITS = 32,
   parameter string INIT_FILE     = ""
) (
   input  logic                     i_clk,
   input  logic                     i_en,
   input  logic [MEM_ADDR_BITS-1:0] i_addr,
   output logic [MEM_DATA_BITS-1:0] o_data
);

   logic [MEM_DATA_BITS-1:0] w_word;
   logic [MEM_DATA_BITS-1:0] r_data;

   // Without an image the array reads as the boot fill pattern base+index.
   // Real images are bound in the technology-mapped macro.
   generate
      if (INIT_FILE == "") begin : g_fill
         assign w_word = MEM_DATA_BITS'(32'hA500_0000)
                       + MEM_DATA_BITS'(i_addr);
      end else begin : g_img
         assign w_word = '0;
      end
   endgenerate

   // Synchronous read port; output holds when not enabled.
   always_ff @(posedge i_clk) begin
      if (i_en) r_data <= w_word;
   end

   assign o_data = r_data;

endmodule

module generic_rom_mc_w #(
   parameter int    NUM_CH        = 2,
   parameter int    MEM_ADDR_BITS = 10,
   parameter int    MEM_DATA_BITS = 32,
   parameter string INIT_FILE     = ""
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NUM_CH-1:0]               i_req_valid,
   input  logic [NUM_CH*MEM_ADDR_BITS-1:0] i_req_addr,
   output logic [NUM_CH-1:0]               o_req_ready,
   output logic [NUM_CH-1:0]               o_rsp_valid,
   output logic [NUM_CH*MEM_DATA_BITS-1:0] o_rsp_data,
   input  logic [NUM_CH-1:0]               i_rsp_ready
);

   localparam int AW = MEM_ADDR_BITS;
   localparam int DW = MEM_DATA_BITS;
   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] r_busy;
   logic [NUM_CH-1:0] r_rsp_valid;
   logic [DW-1:0]     r_rsp_data [NUM_CH];
   logic [PW-1:0]     r_rr_ptr;
   logic [PW-1:0]     r_pend_ch;
   logic              r_pend_v;

   logic [NUM_CH-1:0] w_elig;
   logic [NUM_CH-1:0] w_grant;
   logic [PW-1:0]     w_gnt_idx;
   logic [PW-1:0]     w_rr_next;
   logic              w_gnt_any;
   logic              w_take;
   logic [AW-1:0]     w_rom_addr;
   logic [DW-1:0]     w_rom_data;
   int                w_idx;

   assign w_elig = i_req_valid & ~r_busy;

   // Round-robin search starting at r_rr_ptr; picks the first eligible channel.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_idx     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
         if (!w_gnt_any && w_elig[w_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = PW'(w_idx);
         end
      end
   end

   assign w_take = w_gnt_any & ~i_rst;

   // Grant vector, pointer advance and the muxed ROM address.
   always_comb begin
      w_grant = '0;
      if (w_take) w_grant[w_gnt_idx] = 1'b1;
      if (w_gnt_idx == PW'(NUM_CH - 1)) w_rr_next = '0;
      else                              w_rr_next = w_gnt_idx + PW'(1);
      w_rom_addr = i_req_addr[w_gnt_idx*AW +: AW];
   end

   generic_rom #(
      .MEM_ADDR_BITS (AW),
      .MEM_DATA_BITS (DW),
      .INIT_FILE     (INIT_FILE)
   ) u_rom (
      .i_clk  (i_clk),
      .i_en   (w_take),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   // Channel state: grant marks busy, ROM data lands in the pending channel's
   // slot one cycle later, and a response handshake frees the channel.
   // The pending channel is busy with an empty slot, so capture and drain
   // never target the same slot in one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy      <= '0;
         r_rsp_valid <= '0;
         r_rr_ptr    <= '0;
         r_pend_ch   <= '0;
         r_pend_v    <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) r_rsp_data[k] <= '0;
      end else begin
         r_pend_v <= w_take;
         if (w_take) begin
            r_pend_ch           <= w_gnt_idx;
            r_rr_ptr            <= w_rr_next;
            r_busy[w_gnt_idx]   <= 1'b1;
         end
         for (int k = 0; k < NUM_CH; k++) begin
            if (r_rsp_valid[k] && i_rsp_ready[k]) begin
               r_rsp_valid[k] <= 1'b0;
               r_busy[k]      <= 1'b0;
            end
         end
         if (r_pend_v) begin
            r_rsp_valid[r_pend_ch] <= 1'b1;
            r_rsp_data[r_pend_ch]  <= w_rom_data;
         end
      end
   end

   assign o_req_ready = w_grant;
   assign o_rsp_valid = r_rsp_valid;

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_out
         assign o_rsp_data[k*DW +: DW] = r_rsp_data[k];
      end
   endgenerate

endmodule

// File: tb/tb_generic_rom_mc_w.sv
// tb_generic_rom_mc_w: scenario tasks plus a per-channel response scoreboard
// for the multi-channel ROM wrapper (3 channels, fill-pattern image).

module tb_generic_rom_mc_w;

   localparam int N  = 3;
   localparam int AW = 10;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [N*DW-1:0] rsp_data;
   logic [N-1:0]    rsp_ready;

   int nchecks = 0;
   int nerrors = 0;

   logic [DW-1:0] sbq [N][$];
   int            waitc [N];
   int            done_cnt [N];

   generic_rom_mc_w #(
      .NUM_CH        (N),
      .MEM_ADDR_BITS (AW),
      .MEM_DATA_BITS (DW),
      .INIT_FILE     ("")
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_addr  (req_addr),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_data  (rsp_data),
      .i_rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return 32'hA500_0000 + {22'd0, a};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int k, input logic [AW-1:0] a);
      req_addr[k*AW +: AW] = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Scoreboard monitor, sampled mid-cycle away from the active edge.
   always @(negedge clk) begin
      logic          el;
      logic [AW-1:0] a;
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            sbq[k].delete();
            waitc[k] = 0;
         end
      end else begin
         nchecks++;
         if ($countones(req_ready) > 1) begin
            nerrors++;
            $display("FAIL onehot: req_ready=%b required at most one bit", req_ready);
         end
         for (int k = 0; k < N; k++) begin
            el = req_valid[k] && (sbq[k].size() == 0);
            a  = req_addr[k*AW +: AW];
            if (req_ready[k]) begin
               nchecks++;
               if (!el) begin
                  nerrors++;
                  $display("FAIL grant_illegal ch%0d: ready=1 required 0", k);
               end
            end
            if (el && !req_ready[k]) begin
               waitc[k]++;
               nchecks++;
               if (waitc[k] > N - 1) begin
                  nerrors++;
                  $display("FAIL fairness ch%0d: waited %0d required <= %0d", k, waitc[k], N - 1);
               end
            end else begin
               waitc[k] = 0;
            end
            if (rsp_valid[k]) begin
               nchecks++;
               if (sbq[k].size() == 0) begin
                  nerrors++;
                  $display("FAIL spurious_rsp ch%0d: data=%h required no response", k,
                           rsp_data[k*DW +: DW]);
               end else begin
                  if (rsp_data[k*DW +: DW] !== sbq[k][0]) begin
                     nerrors++;
                     $display("FAIL rsp_data ch%0d: got %h required %h", k,
                              rsp_data[k*DW +: DW], sbq[k][0]);
                  end
                  if (rsp_ready[k]) begin
                     void'(sbq[k].pop_front());
                     done_cnt[k]++;
                  end
               end
            end
            if (req_valid[k] && req_ready[k]) sbq[k].push_back(word_of(a));
         end
      end
   end

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = '1;
      req_addr  = '0;
      step();
      step();
      @(negedge clk);
      nchecks++;
      if (req_ready !== 3'b000) begin
         nerrors++;
         $display("FAIL reset_ready: got %b required 000", req_ready);
      end
      nchecks++;
      if (rsp_valid !== 3'b000) begin
         nerrors++;
         $display("FAIL reset_rsp_valid: got %b required 000", rsp_valid);
      end
      nchecks++;
      if (rsp_data !== '0) begin
         nerrors++;
         $display("FAIL reset_rsp_data: got %h required 0", rsp_data);
      end
      rst       = 1'b0;
      req_valid = '0;
      step();
   endtask

   task automatic test_single();
      rsp_ready = '1;
      req_valid = 3'b001;
      set_addr(0, 10'h010);
      @(negedge clk);
      nchecks++;
      if (req_ready !== 3'b001) begin
         nerrors++;
         $display("FAIL single_ready: got %b required 001", req_ready);
      end
      step();
      req_valid = '0;
      @(negedge clk);
      nchecks++;
      if (rsp_valid !== 3'b000) begin
         nerrors++;
         $display("FAIL single_early: rsp_valid=%b required 000", rsp_valid);
      end
      step();
      @(negedge clk);
      nchecks++;
      if (rsp_valid !== 3'b001 || rsp_data[0 +: DW] !== 32'hA500_0010) begin
         nerrors++;
         $display("FAIL single_rsp: valid=%b data=%h required 001 a5000010",
                  rsp_valid, rsp_data[0 +: DW]);
      end
      step();
      @(negedge clk);
      nchecks++;
      if (rsp_valid !== 3'b000 || rsp_data[0 +: DW] !== 32'hA500_0010) begin
         nerrors++;
         $display("FAIL single_after: valid=%b data=%h required 000 a5000010",
                  rsp_valid, rsp_data[0 +: DW]);
      end
      step();
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_g;
      do_reset();
      req_valid = '1;
      rsp_ready = '1;
      for (int c = 0; c < 9; c++) begin
         for (int k = 0; k < N; k++) set_addr(k, AW'(k * 64 + c));
         exp_g = N'(1 << (c % N));
         @(negedge clk);
         nchecks++;
         if (req_ready !== exp_g) begin
            nerrors++;
            $display("FAIL contention_grant c%0d: got %b required %b", c, req_ready, exp_g);
         end
         step();
      end
      req_valid = '0;
      repeat (4) step();
   endtask

   task automatic test_backpressure();
      bit got;
      int d0;
      int d2;
      rsp_ready = 3'b101;
      req_valid = 3'b111;
      set_addr(1, 10'h3FF);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         set_addr(0, AW'(i));
         set_addr(2, AW'(100 + i));
         @(negedge clk);
         if (req_ready[1]) got = 1;
         step();
      end
      nchecks++;
      if (!got) begin
         nerrors++;
         $display("FAIL bp_grant: ch1 not granted within 10 cycles");
      end
      d0 = done_cnt[0];
      d2 = done_cnt[2];
      for (int i = 0; i < 12; i++) begin
         set_addr(0, AW'(200 + i));
         set_addr(2, AW'(300 + i));
         @(negedge clk);
         nchecks++;
         if (req_ready[1] !== 1'b0) begin
            nerrors++;
            $display("FAIL bp_ready1 i%0d: got 1 required 0", i);
         end
         if (i >= 1) begin
            nchecks++;
            if (rsp_valid[1] !== 1'b1 || rsp_data[DW +: DW] !== 32'hA500_03FF) begin
               nerrors++;
               $display("FAIL bp_hold i%0d: valid=%b data=%h required 1 a50003ff",
                        i, rsp_valid[1], rsp_data[DW +: DW]);
            end
         end
         step();
      end
      nchecks++;
      if (done_cnt[0] <= d0 || done_cnt[2] <= d2) begin
         nerrors++;
         $display("FAIL bp_others: ch0 +%0d ch2 +%0d required both > 0",
                  done_cnt[0] - d0, done_cnt[2] - d2);
      end
      rsp_ready = 3'b111;
      req_valid = 3'b010;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (req_ready[1]) got = 1;
         step();
      end
      nchecks++;
      if (!got) begin
         nerrors++;
         $display("FAIL bp_regrant: ch1 not regranted within 6 cycles of release");
      end
      req_valid = '0;
      repeat (4) step();
   endtask

   task automatic test_addr_sample();
      bit got;
      rsp_ready = '1;
      req_valid = 3'b100;
      set_addr(2, 10'h005);
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (req_ready[2]) got = 1;
         step();
      end
      nchecks++;
      if (!got) begin
         nerrors++;
         $display("FAIL addr_grant: ch2 not granted within 6 cycles");
      end
      set_addr(2, 10'h006);
      req_valid = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      nchecks++;
      if (rsp_valid[2] !== 1'b1 || rsp_data[2*DW +: DW] !== 32'hA500_0005) begin
         nerrors++;
         $display("FAIL addr_sample: valid=%b data=%h required 1 a5000005",
                  rsp_valid[2], rsp_data[2*DW +: DW]);
      end
      step();
      repeat (2) step();
   endtask

   task automatic test_reset_midflight();
      bit got;
      rsp_ready = '1;
      req_valid = 3'b001;
      set_addr(0, 10'h020);
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (req_ready[0]) got = 1;
         step();
      end
      nchecks++;
      if (!got) begin
         nerrors++;
         $display("FAIL mid_grant: ch0 not granted within 6 cycles");
      end
      req_valid = '0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nchecks++;
         if (rsp_valid !== '0 || rsp_data !== '0 || req_ready !== '0) begin
            nerrors++;
            $display("FAIL mid_outputs i%0d: valid=%b ready=%b data=%h required all 0",
                     i, rsp_valid, req_ready, rsp_data);
         end
         step();
      end
      req_valid = 3'b111;
      @(negedge clk);
      nchecks++;
      if (req_ready !== 3'b001) begin
         nerrors++;
         $display("FAIL mid_rrptr: got %b required 001", req_ready);
      end
      step();
      req_valid = '0;
      repeat (4) step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         req_valid = N'($urandom);
         rsp_ready = N'($urandom_range(7, 0) | (c[3] ? 3'b111 : 3'b000));
         for (int k = 0; k < N; k++) set_addr(k, AW'($urandom));
         step();
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (6) step();
      for (int k = 0; k < N; k++) begin
         nchecks++;
         if (sbq[k].size() != 0) begin
            nerrors++;
            $display("FAIL rand_drain ch%0d: %0d responses lost required 0", k, sbq[k].size());
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         waitc[k]    = 0;
         done_cnt[k] = 0;
      end
      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      rsp_ready = '0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_addr_sample();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
      $finish;
   end

endmodule
